// File: rtl/led_mode_drv.sv
// led_mode_drv: turns the key controller's 2-bit mode word into an LED waveform.
//   00 off, 01 on, 10 blink, 11 breath (PWM with ramping duty).
// Optional feature macro: BREATH_EN.
//   When BREATH_EN is defined, mode 11 is the PWM breathing pattern.
//   When it is not defined, the PWM logic is left out and mode 11 becomes a
//   fast blink with half-period BLINK_HALF/2 (at least 1 cycle).
// Every captured change of ctrl restarts the pattern and pulses mode_chg.
// A restart takes priority over any counter wrap in the same cycle.
module led_mode_drv #(
    parameter int BLINK_HALF  = 24,
    parameter int PWM_PERIOD  = 16,
    parameter int BREATH_STEP = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] ctrl,
    output logic       led,
    output logic       mode_chg
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_ON     = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_BREATH = 2'b11
    } mode_t;

    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_HALF - 1);

`ifdef BREATH_EN
    localparam int PW = $clog2(PWM_PERIOD);
    localparam int DW = $clog2(PWM_PERIOD + 1);
    localparam int FW = (BREATH_STEP > 1) ? $clog2(BREATH_STEP) : 1;
    localparam logic [PW-1:0] PWM_TERM   = PW'(PWM_PERIOD - 1);
    localparam logic [DW-1:0] DUTY_MAX   = DW'(PWM_PERIOD);
    localparam logic [FW-1:0] FRAME_TERM = FW'(BREATH_STEP - 1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;
`else
    localparam int FAST_HALF = (BLINK_HALF / 2 < 1) ? 1 : BLINK_HALF / 2;
    localparam logic [BW-1:0] FAST_TERM = BW'(FAST_HALF - 1);
`endif

    // Elaboration-time guard against parameter values the counters cannot honour.
    if (BLINK_HALF < 2 || PWM_PERIOD < 2 || BREATH_STEP < 1) begin : g_param_check
        $error("led_mode_drv: BLINK_HALF>=2, PWM_PERIOD>=2, BREATH_STEP>=1 required");
    end

    mode_t          ctrl_q;
    mode_t          ctrl_prev;
    logic           chg;
    logic           led_nxt;

    logic [BW-1:0]  blink_cnt;
    logic [BW-1:0]  blink_cnt_nxt;
    logic [BW-1:0]  blink_term;
    logic           blink_q;
    logic           blink_q_nxt;
    logic           blink_active;

`ifdef BREATH_EN
    logic [PW-1:0]  pwm_cnt;
    logic [PW-1:0]  pwm_nxt;
    logic [FW-1:0]  frame_cnt;
    logic [FW-1:0]  frame_nxt;
    logic [DW-1:0]  duty;
    logic [DW-1:0]  duty_nxt;
    dir_t           dir;
    dir_t           dir_nxt;

    assign blink_active = (ctrl_q == MODE_BLINK);
`else
    assign blink_active = ctrl_q[1];
`endif

    // The captured mode differs from the one captured the cycle before.
    assign chg = (ctrl_q != ctrl_prev);

    // Capture ctrl, remember the previous capture, and register led and mode_chg.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q    <= MODE_OFF;
            ctrl_prev <= MODE_OFF;
            led       <= 1'b0;
            mode_chg  <= 1'b0;
        end else begin
            ctrl_q    <= mode_t'(ctrl);
            ctrl_prev <= ctrl_q;
            led       <= led_nxt;
            mode_chg  <= chg;
        end
    end

    // Blink counter: restart ON after a change, toggle on each half-period wrap.
    always_comb begin
        blink_term    = BLINK_TERM;
`ifndef BREATH_EN
        if (ctrl_q == MODE_BREATH) begin
            blink_term = FAST_TERM;
        end
`endif
        blink_cnt_nxt = '0;
        blink_q_nxt   = 1'b0;
        if (chg) begin
            blink_q_nxt = 1'b1;
        end else if (blink_active) begin
            if (blink_cnt == blink_term) begin
                blink_cnt_nxt = '0;
                blink_q_nxt   = ~blink_q;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
                blink_q_nxt   = blink_q;
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt_nxt;
            blink_q   <= blink_q_nxt;
        end
    end

`ifdef BREATH_EN
    // Breath counters: PWM position, frames per duty value, and a duty ramp that bounces 0..max.
    always_comb begin
        pwm_nxt   = '0;
        frame_nxt = '0;
        duty_nxt  = '0;
        dir_nxt   = DIR_UP;
        if (!chg && ctrl_q == MODE_BREATH) begin
            pwm_nxt   = pwm_cnt + PW'(1);
            frame_nxt = frame_cnt;
            duty_nxt  = duty;
            dir_nxt   = dir;
            if (pwm_cnt == PWM_TERM) begin
                pwm_nxt = '0;
                if (frame_cnt == FRAME_TERM) begin
                    frame_nxt = '0;
                    if (dir == DIR_UP) begin
                        if (duty < DUTY_MAX) begin
                            duty_nxt = duty + DW'(1);
                        end
                        if (duty_nxt == DUTY_MAX) begin
                            dir_nxt = DIR_DOWN;
                        end
                    end else begin
                        if (duty != '0) begin
                            duty_nxt = duty - DW'(1);
                        end
                        if (duty_nxt == '0) begin
                            dir_nxt = DIR_UP;
                        end
                    end
                end else begin
                    frame_nxt = frame_cnt + FW'(1);
                end
            end
        end
    end

    // Breath state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt   <= '0;
            frame_cnt <= '0;
            duty      <= '0;
            dir       <= DIR_UP;
        end else begin
            pwm_cnt   <= pwm_nxt;
            frame_cnt <= frame_nxt;
            duty      <= duty_nxt;
            dir       <= dir_nxt;
        end
    end
`endif

    // LED value for the next cycle, taken from the pattern state being loaded alongside it.
    always_comb begin
        led_nxt = 1'b0;
        case (ctrl_q)
            MODE_OFF:    led_nxt = 1'b0;
            MODE_ON:     led_nxt = 1'b1;
            MODE_BLINK:  led_nxt = blink_q_nxt;
`ifdef BREATH_EN
            MODE_BREATH: led_nxt = (DW'(pwm_nxt) < duty_nxt);
`else
            MODE_BREATH: led_nxt = blink_q_nxt;
`endif
            default:     led_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_led_mode_drv.sv
// tb_led_mode_drv: directed vector table, hand-written corner sequences and
// randomized mode changes checked against a reference model computed from
// the time elapsed since the latest mode entry. Follows BREATH_EN like the DUT.
module tb_led_mode_drv;

    localparam int BH = 4;
    localparam int PP = 4;
    localparam int BS = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] ctrl;
    logic       led;
    logic       mode_chg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: captured mode, previous capture, cycles since entry.
    logic [1:0] m_q;
    logic [1:0] m_prev;
    int         m_age;
    logic       m_led;
    logic       m_chg;

    typedef struct {
        logic [1:0] ctrl;
        logic       led;
        logic       chg;
    } vec_t;

    vec_t vecs[24];

    led_mode_drv #(
        .BLINK_HALF (BH),
        .PWM_PERIOD (PP),
        .BREATH_STEP(BS)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ctrl    (ctrl),
        .led     (led),
        .mode_chg(mode_chg)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic logic ref_led(input logic [1:0] mode, input int t);
        int f;
        int pos;
        int k;
        int duty;
        case (mode)
            2'b00: return 1'b0;
            2'b01: return 1'b1;
            2'b10: return ((t / BH) % 2) == 0;
            default: begin
`ifdef BREATH_EN
                f    = t / PP;
                pos  = t % PP;
                k    = (f / BS) % (2 * PP);
                duty = (k <= PP) ? k : 2 * PP - k;
                return pos < duty;
`else
                f = (BH / 2 < 1) ? 1 : BH / 2;
                return ((t / f) % 2) == 0;
`endif
            end
        endcase
    endfunction

    task automatic modelReset();
        m_q    = 2'b00;
        m_prev = 2'b00;
        m_age  = 0;
        m_led  = 1'b0;
        m_chg  = 1'b0;
    endtask

    task automatic modelEdge(input logic [1:0] c);
        m_chg = (m_q != m_prev);
        if (m_chg) m_age = 0;
        else       m_age = m_age + 1;
        m_led  = ref_led(m_q, m_age);
        m_prev = m_q;
        m_q    = c;
    endtask

    task automatic applyStimulus(input logic [1:0] c);
        @(negedge clk);
        ctrl = c;
        @(posedge clk);
        modelEdge(c);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_led, input logic exp_chg);
        n_checks++;
        if (led !== exp_led || mode_chg !== exp_chg) begin
            n_fail++;
            $display("[TB] FAIL %s @%0t: got led=%b mode_chg=%b, expected led=%b mode_chg=%b",
                     name, $time, led, mode_chg, exp_led, exp_chg);
        end
    endtask

    task automatic holdReset(input int cycles);
        @(negedge clk);
        rstn = 1'b0;
        ctrl = 2'b01;
        modelReset();
        repeat (cycles) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", 1'b0, 1'b0);
        end
        rstn = 1'b1;
    endtask

    task automatic asyncReset();
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("async_reset_hold", 1'b0, 1'b0);
        rstn = 1'b1;
    endtask

    initial begin
        logic [1:0] cur;
        rstn = 1'b0;
        ctrl = 2'b01;
        modelReset();
        $display("[TB] start, BLINK_HALF=%0d PWM_PERIOD=%0d BREATH_STEP=%0d", BH, PP, BS);

        // Vector table: ctrl driven before each edge, outputs expected after it.
        vecs[0]  = '{2'b01, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 1'b1, 1'b1};
        vecs[2]  = '{2'b01, 1'b1, 1'b0};
        vecs[3]  = '{2'b00, 1'b1, 1'b0};
        vecs[4]  = '{2'b00, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 1'b1, 1'b1};
        vecs[7]  = '{2'b10, 1'b1, 1'b0};
        vecs[8]  = '{2'b10, 1'b1, 1'b0};
        vecs[9]  = '{2'b10, 1'b1, 1'b0};
        vecs[10] = '{2'b10, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 1'b0, 1'b0};
        vecs[13] = '{2'b10, 1'b0, 1'b0};
        vecs[14] = '{2'b10, 1'b1, 1'b0};
        vecs[15] = '{2'b10, 1'b1, 1'b0};
        vecs[16] = '{2'b10, 1'b1, 1'b0};
        vecs[17] = '{2'b10, 1'b1, 1'b0};
        vecs[18] = '{2'b11, 1'b0, 1'b0};
`ifdef BREATH_EN
        vecs[19] = '{2'b11, 1'b0, 1'b1};
        vecs[20] = '{2'b11, 1'b0, 1'b0};
        vecs[21] = '{2'b11, 1'b0, 1'b0};
        vecs[22] = '{2'b11, 1'b0, 1'b0};
        vecs[23] = '{2'b11, 1'b0, 1'b0};
`else
        vecs[19] = '{2'b11, 1'b1, 1'b1};
        vecs[20] = '{2'b11, 1'b1, 1'b0};
        vecs[21] = '{2'b11, 1'b0, 1'b0};
        vecs[22] = '{2'b11, 1'b0, 1'b0};
        vecs[23] = '{2'b11, 1'b1, 1'b0};
`endif

        holdReset(5);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].ctrl);
            checkOutput($sformatf("table[%0d]", i), vecs[i].led, vecs[i].chg);
        end

        // Collision: the change reaches the edge where blink_cnt would wrap.
        applyStimulus(2'b10);
        applyStimulus(2'b10);
        checkOutput("collision_entry", 1'b1, 1'b1);
        applyStimulus(2'b10);
        applyStimulus(2'b10);
        applyStimulus(2'b11);
        checkOutput("collision_pre", 1'b1, 1'b0);
        applyStimulus(2'b11);
`ifdef BREATH_EN
        checkOutput("collision_edge", 1'b0, 1'b1);
        applyStimulus(2'b11);
        checkOutput("collision_after", 1'b0, 1'b0);
`else
        checkOutput("collision_edge", 1'b1, 1'b1);
        applyStimulus(2'b11);
        checkOutput("collision_after", 1'b1, 1'b0);
        applyStimulus(2'b11);
        checkOutput("collision_after2", 1'b0, 1'b0);
`endif

        // Mid-pattern switch from blink (high, blink_cnt=2) to mode 11.
        applyStimulus(2'b10);
        applyStimulus(2'b10);
        applyStimulus(2'b10);
        applyStimulus(2'b11);
        checkOutput("midswitch_capture", 1'b1, 1'b0);
        applyStimulus(2'b11);
        checkOutput("midswitch_pulse", m_led, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b11);
            checkOutput("midswitch_run", m_led, 1'b0);
        end

        // Long run in mode 11 covering a full pattern against the model.
        for (int i = 0; i < 2 * PP * BS * PP + 8; i++) begin
            applyStimulus(2'b11);
            checkOutput("mode11_run", m_led, m_chg);
        end

        // Randomized mode changes, with one asynchronous reset in the middle.
        cur = 2'b00;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                asyncReset();
            end
            if ($urandom_range(7) == 0) begin
                cur = 2'($urandom_range(3));
            end
            applyStimulus(cur);
            checkOutput("random", m_led, m_chg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
